// File: rtl/fpmult_share_ctrl.sv
// fpmult_share_ctrl: round-robin arbiter/sequencer that shares one multi-cycle
// 8-bit FP multiplier ({sign, exp[2:0], mant[3:0]}) among NUM_REQ requesters.
// One operation is outstanding at a time: IDLE -> ISSUE -> WAIT -> RESP.
module fpmult_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic [7:0]           rsp_z,
  output logic [4:0]           rsp_flags,
  output logic                 rsp_timeout,
  output logic                 mult_start,
  output logic [7:0]           mult_a,
  output logic [7:0]           mult_b,
  input  logic                 mult_done,
  input  logic [7:0]           mult_z,
  input  logic [4:0]           mult_flags,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);
  localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT - 1);
  localparam logic [IW:0]   NREQ      = (IW+1)'(NUM_REQ);

  logic [1:0]                state;
  logic [IW-1:0]             last_grant;
  logic [IW-1:0]             owner;
  logic [TW-1:0]             timer;
  logic [IW-1:0]             win;
  logic                      win_vld;
  logic [NUM_REQ-1:0][7:0]   a_arr;
  logic [NUM_REQ-1:0][7:0]   b_arr;

  assign a_arr = req_a;
  assign b_arr = req_b;

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin : arb
    logic [IW:0] j;
    j       = '0;
    win     = '0;
    win_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = {1'b0, last_grant} + (IW+1)'(i + 1);
      if (j >= NREQ) j = j - NREQ;
      if (!win_vld && req_valid[j[IW-1:0]]) begin
        win_vld = 1'b1;
        win     = j[IW-1:0];
      end
    end
  end

  // Accept strobe to the winner only while idle; gated by reset so the
  // strobe reads 0 while reset is held even if requesters are valid.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == S_IDLE && win_vld) req_ready[win] = 1'b1;
  end

  // Result valid routed to the owning requester only.
  always_comb begin
    rsp_valid = '0;
    if (state == S_RESP) rsp_valid[owner] = 1'b1;
  end

  assign mult_start = (state == S_ISSUE);
  assign busy       = (state != S_IDLE);

  // Sequencer: operand capture, done/timeout wait, response hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      last_grant  <= LAST_INIT;
      owner       <= '0;
      timer       <= '0;
      mult_a      <= '0;
      mult_b      <= '0;
      rsp_z       <= '0;
      rsp_flags   <= '0;
      rsp_timeout <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            mult_a <= a_arr[win];
            mult_b <= b_arr[win];
            owner  <= win;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // done takes precedence over a coincident timeout
          if (mult_done) begin
            rsp_z       <= mult_z;
            rsp_flags   <= mult_flags;
            rsp_timeout <= 1'b0;
            state       <= S_RESP;
          end else if (timer == TMAX) begin
            rsp_z       <= '0;
            rsp_flags   <= '0;
            rsp_timeout <= 1'b1;
            state       <= S_RESP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready[owner]) begin
            last_grant <= owner;
            op_count   <= op_count + CNT_W'(1);
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
